// File: rtl/credit_counter_if.sv
// credit_counter_if: bundles the coin/start/game-control inputs and the
// credit-display / game-control outputs of credit_counter.
// master = the environment driving keys and consuming outputs,
// slave  = the credit_counter itself.
interface credit_counter_if;
  logic       coinKey;
  logic       startKey;
  logic       gameOver;
  logic [3:0] credits;
  logic       coinAccepted;
  logic       startGranted;
  logic       playing;

  modport master (
    output coinKey,
    output startKey,
    output gameOver,
    input  credits,
    input  coinAccepted,
    input  startGranted,
    input  playing
  );

  modport slave (
    input  coinKey,
    input  startKey,
    input  gameOver,
    output credits,
    output coinAccepted,
    output startGranted,
    output playing
  );
endinterface

// File: rtl/credit_counter.sv
// credit_counter: debounces the coin key, keeps a saturating one-digit credit
// count, grants game starts by spending a credit and tracks ATTRACT/PLAYING.
// All outputs come straight from flops.
// Optional feature macro: FREE_PLAY_EN -- credits pinned at MAX_CREDITS and
// starts never consume a credit.
module credit_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_CREDITS     = 9,
  parameter int COIN_VALUE      = 1
) (
  input  logic              clk,
  input  logic              reset,
  credit_counter_if.slave   bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [4:0]        MAX5     = 5'(MAX_CREDITS);
  localparam logic [4:0]        COIN5    = 5'(COIN_VALUE);
`ifdef FREE_PLAY_EN
  localparam logic [3:0]        CRED_RST = 4'(MAX_CREDITS);
`else
  localparam logic [3:0]        CRED_RST = 4'd0;
`endif

  typedef enum logic [0:0] {
    ATTRACT = 1'b0,
    PLAYING = 1'b1
  } state_t;

  state_t           state;
  state_t           nextState;
  logic             syncMeta;
  logic             coinSync;
  logic [CNT_W-1:0] debCnt;
  logic             armed;
  logic             startKeyQ;
  logic [3:0]       creditsQ;
  logic             coinAcceptedQ;
  logic             startGrantedQ;
  logic             playingQ;

  logic             coinFire;
  logic             startPress;
  logic             grant;
  logic [4:0]       credWithCoin;
  logic [3:0]       creditsNext;

  // Two-flop synchronizer for the asynchronous coin key plus the start-key edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta  <= 1'b0;
      coinSync  <= 1'b0;
      startKeyQ <= 1'b0;
    end else begin
      syncMeta  <= bus.coinKey;
      coinSync  <= syncMeta;
      startKeyQ <= bus.startKey;
    end
  end

  // Debounce counter: counts a stable synchronized press, disarms after one coin until release.
  always_ff @(posedge clk) begin
    if (reset) begin
      debCnt <= '0;
      armed  <= 1'b1;
    end else if (!coinSync) begin
      debCnt <= '0;
      armed  <= 1'b1;
    end else if (armed) begin
      if (debCnt != CNT_TOP) begin
        debCnt <= debCnt + CNT_W'(1);
      end
      if (coinFire) begin
        armed <= 1'b0;
      end
    end
  end

  // Coin event, start edge, grant decision, next FSM state and next credit count.
  always_comb begin
    coinFire     = armed && coinSync && (debCnt == CNT_LAST);
    startPress   = bus.startKey && !startKeyQ;
    credWithCoin = {1'b0, creditsQ} + (coinFire ? COIN5 : 5'd0);
    grant        = 1'b0;
    nextState    = state;
    creditsNext  = creditsQ;
    case (state)
      ATTRACT: begin
`ifdef FREE_PLAY_EN
        if (startPress) begin
`else
        // The coin of this cycle counts before the start is judged.
        if (startPress && (credWithCoin != 5'd0)) begin
`endif
          grant     = 1'b1;
          nextState = PLAYING;
        end else begin
          nextState = ATTRACT;
        end
      end
      PLAYING: begin
        if (bus.gameOver) begin
          nextState = ATTRACT;
        end else begin
          nextState = PLAYING;
        end
      end
      default: begin
        nextState = ATTRACT;
      end
    endcase
`ifdef FREE_PLAY_EN
    creditsNext = 4'(MAX_CREDITS);
`else
    if ((credWithCoin - (grant ? 5'd1 : 5'd0)) > MAX5) begin
      creditsNext = MAX5[3:0];
    end else begin
      creditsNext = 4'(credWithCoin - (grant ? 5'd1 : 5'd0));
    end
`endif
  end

  // FSM state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ATTRACT;
      creditsQ      <= CRED_RST;
      coinAcceptedQ <= 1'b0;
      startGrantedQ <= 1'b0;
      playingQ      <= 1'b0;
    end else begin
      state         <= nextState;
      creditsQ      <= creditsNext;
      coinAcceptedQ <= coinFire;
      startGrantedQ <= grant;
      playingQ      <= (nextState == PLAYING);
    end
  end

  assign bus.credits      = creditsQ;
  assign bus.coinAccepted = coinAcceptedQ;
  assign bus.startGranted = startGrantedQ;
  assign bus.playing      = playingQ;

endmodule

// File: tb/tb_credit_counter.sv
// tb_credit_counter: directed, table-driven bench for credit_counter with
// DEBOUNCE_CYCLES=4, MAX_CREDITS=9, COIN_VALUE=1. Honours FREE_PLAY_EN.
module tb_credit_counter;

  typedef struct {
    logic       ck;
    logic       sk;
    logic       go;
    logic [3:0] cr;
    logic       ca;
    logic       sg;
    logic       pl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passCount = 0;
  int   checkCount = 0;
  int   pulses;
  vec_t vecs[$];

  credit_counter_if bus ();

  credit_counter #(
    .DEBOUNCE_CYCLES(4),
    .MAX_CREDITS    (9),
    .COIN_VALUE     (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input int idx, input logic [3:0] cr,
                        input logic ca, input logic sg, input logic pl);
    chk({name, ".credits"}, idx, bus.credits, cr);
    chk({name, ".coinAccepted"}, idx, {3'd0, bus.coinAccepted}, {3'd0, ca});
    chk({name, ".startGranted"}, idx, {3'd0, bus.startGranted}, {3'd0, sg});
    chk({name, ".playing"}, idx, {3'd0, bus.playing}, {3'd0, pl});
  endtask

  // Apply one cycle of inputs, clock once, then compare all outputs.
  task automatic cyc(input string name, input int idx, input logic ck, input logic sk, input logic go,
                     input logic [3:0] cr, input logic ca, input logic sg, input logic pl);
    bus.coinKey  = ck;
    bus.startKey = sk;
    bus.gameOver = go;
    tick();
    check4(name, idx, cr, ca, sg, pl);
  endtask

  task automatic addVec(input logic ck, input logic sk, input logic go,
                        input logic [3:0] cr, input logic ca, input logic sg, input logic pl);
    vec_t v;
    v.ck = ck; v.sk = sk; v.go = go; v.cr = cr; v.ca = ca; v.sg = sg; v.pl = pl;
    vecs.push_back(v);
  endtask

  task automatic doReset(input logic [3:0] crRst);
    reset = 1'b1;
    bus.coinKey = 1'b0; bus.startKey = 1'b0; bus.gameOver = 1'b0;
    tick();
    check4("reset", 0, crRst, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    bus.coinKey = 1'b0; bus.startKey = 1'b0; bus.gameOver = 1'b0;
`ifndef FREE_PLAY_EN
    // Held coin key: one coin on the 6th edge, none afterwards.
    for (int i = 1; i <= 20; i++) addVec(1'b1, 1'b0, 1'b0, (i >= 6) ? 4'd1 : 4'd0, (i == 6), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  addVec(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    // Three-cycle glitch: no coin.
    for (int i = 0; i < 3; i++)  addVec(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  addVec(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    // Second clean coin -> credits 2.
    for (int i = 1; i <= 6; i++) addVec(1'b1, 1'b0, 1'b0, (i == 6) ? 4'd2 : 4'd1, (i == 6), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  addVec(1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    // Start, held key, second edge while playing, gameOver, gameOver in ATTRACT.
    addVec(1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    // Spend last credit, end game, then a start with zero credits is ignored.
    addVec(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    doReset(4'd0);
    foreach (vecs[i]) cyc("vec", i, vecs[i].ck, vecs[i].sk, vecs[i].go, vecs[i].cr, vecs[i].ca, vecs[i].sg, vecs[i].pl);

    // Coin and start edge on the same cycle with zero credits: granted, net 0.
    for (int t = 1; t <= 5; t++) cyc("coinStart", t, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("coinStart", 6, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    cyc("coinStart", 7, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int t = 8; t <= 10; t++) cyc("coinStart", t, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Twelve clean presses saturate at 9.
    doReset(4'd0);
    pulses = 0;
    for (int p = 1; p <= 12; p++) begin
      for (int t = 1; t <= 6; t++) begin
        cyc("sat", p * 10 + t, 1'b1, 1'b0, 1'b0, (t == 6) ? 4'((p > 9) ? 9 : p) : 4'((p - 1 > 9) ? 9 : p - 1),
            (t == 6), 1'b0, 1'b0);
        if (bus.coinAccepted) pulses++;
      end
      for (int t = 7; t <= 9; t++) begin
        cyc("sat", p * 10 + t, 1'b0, 1'b0, 1'b0, 4'((p > 9) ? 9 : p), 1'b0, 1'b0, 1'b0);
        if (bus.coinAccepted) pulses++;
      end
    end
    chk("satPulses", 0, 4'(pulses), 4'd12);

    // Reset mid-game and mid-debounce discards everything.
    cyc("midReset", 0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1);
    for (int t = 1; t <= 3; t++) cyc("midReset", t, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    check4("midReset", 4, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int t = 1; t <= 6; t++) cyc("postReset", t, 1'b1, 1'b0, 1'b0, (t == 6) ? 4'd1 : 4'd0, (t == 6), 1'b0, 1'b0);
    cyc("postReset", 7, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
`else
    // Free play: credits pinned at 9, starts always granted without decrement.
    doReset(4'd9);
    cyc("free", 1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1);
    cyc("free", 2, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 6; t++) cyc("freeCoin", t, 1'b1, 1'b0, 1'b0, 4'd9, (t == 6), 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    check4("freeMidReset", 0, 4'd9, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("free", 3, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1);
    cyc("free", 4, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc("free", 5, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1);
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/credit_counter.md
Name: credit_counter

Overview:
- Upstream feeder of the main-screen credit display. Replaces its hard-wired digit 0 with the live credit count.
- Debounces the coin key and counts credits, saturating at one decimal digit.
- Grants game start by consuming one credit, and tracks an ATTRACT/PLAYING state machine.
- Outputs drive the credit digit bitmap and the game-control logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive synchronized-high cycles on coinKey needed to accept one coin (min 1).
- MAX_CREDITS, 9, saturation value of credits; must be at most 9 (single display digit).
- COIN_VALUE, 1, credits added per accepted coin; the sum is clamped to MAX_CREDITS.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- coinKey  input  1  raw coin key level, asynchronous to clk, active-high
- startKey  input  1  start request, clk-synchronous, already debounced, active-high level
- gameOver  input  1  single-cycle pulse from game logic at end of game
- credits  output  4  current credit count, 0..MAX_CREDITS, unsigned; feeds the digit bitmap number input
- coinAccepted  output  1  single-cycle pulse when a coin is credited
- startGranted  output  1  single-cycle pulse when a game starts
- playing  output  1  high while in PLAYING

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - On reset: credits=0, coinAccepted=0, startGranted=0, playing=0, FSM=ATTRACT, synchronizer flops=0, debounce counter=0, armed=1, startKey edge register=0.
  - Reset mid-debounce or mid-game discards all progress; no credit is refunded or retained.
- Coin path:
  - coinKey passes through a 2-flop synchronizer to give coinSync.
  - Debounce counter: increments while coinSync=1 and armed=1; clears to 0 when coinSync=0.
  - When the counter equals DEBOUNCE_CYCLES-1 and coinSync=1, the next cycle sets coinAccepted=1 for exactly one cycle and clears armed.
  - armed returns to 1 on the first cycle with coinSync=0. Holding the key gives exactly one coin.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no coin.
  - Latency: a clean press stable from cycle 0 gives coinAccepted in cycle 2+DEBOUNCE_CYCLES. credits updates in the same cycle that coinAccepted is high.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
- Credit arithmetic:
  - Compute in 5 bits: next = credits + (coin ? COIN_VALUE : 0) - (grant ? 1 : 0), then clamp to MAX_CREDITS.
  - Coin at credits=MAX_CREDITS: coinAccepted still pulses, credits stays MAX_CREDITS.
  - Coin and grant in the same cycle: both apply, so the net change is COIN_VALUE-1 (clamped).
- Start: startPress is the rising edge of startKey (one registered copy).
- FSM:
  - ATTRACT:
    - On startPress with credits>0: startGranted=1 for one cycle, credits decrements, next state PLAYING.
    - startPress with credits==0 is ignored and not remembered.
    - A coin and startPress in the same cycle with credits==0: the coin counts first, so the start is granted and net credits = COIN_VALUE-1.
  - PLAYING:
    - playing=1. startPress is ignored. Coins still accumulate.
    - gameOver pulse: next state ATTRACT. playing drops the following cycle.
  - gameOver while in ATTRACT is ignored.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
- FREE_PLAY_EN
- Defined:
  - credits is held at MAX_CREDITS from reset onward.
  - startPress in ATTRACT always grants and does not decrement.
  - coinAccepted still pulses, with no count change.
- Undefined: normal behaviour as specified above.

Test Plan:
- Reset then DEBOUNCE_CYCLES=4, coinKey high for 20 cycles: exactly one coinAccepted, in cycle 6 after the rise; credits=1. Key held, no second pulse.
- coinKey pulsed high for 3 cycles with DEBOUNCE_CYCLES=4: no coinAccepted, credits stays 0.
- 12 clean presses: coinAccepted pulses 12 times, credits saturates at 9.
- credits=2, startKey rising edge: startGranted one cycle, credits=1, playing=1. A second startKey edge is ignored. gameOver pulse: playing=0 one cycle later.
- credits=0, startKey edge in ATTRACT: no grant, credits=0, playing=0. Then coinAccepted and startPress coincide: startGranted=1, credits=0, playing=1.
- FREE_PLAY_EN defined: after reset credits=9; startKey edge grants and credits stays 9. Reset asserted mid-PLAYING gives all outputs at reset values the next cycle.
